// File: rtl/gb_pkg.sv
// Shared Game Boy bus definitions: DMA state encoding, read-select encoding
// and the fixed address map constants used by the OAM DMA arbiter.
package gb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } dma_state_t;

   typedef enum logic [1:0] {
      SEL_BUS = 2'd0,
      SEL_SRC = 2'd1,
      SEL_FF  = 2'd2
   } rd_sel_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hff46;
   localparam logic [15:0] HRAM_LO      = 16'hff80;
   localparam logic [15:0] HRAM_HI      = 16'hfffe;
   localparam int          OAM_LEN      = 160;
   localparam logic [7:0]  ECHO_BASE    = 8'he0;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA controller and CPU bus arbiter: copies LENGTH bytes from page
// {src, 00} into the ppu sprite table while fencing the CPU off to HRAM.
//
// state | meaning
// IDLE  | CPU owns the bus; wr_pend marks the trailing OAM write cycle
// START | one dead cycle after the trigger, CPU limited to HRAM
// RUN   | DMA reads {page, idx} each cycle, writes the previous byte to OAM
module oam_dma
   import gb_pkg::*;
#(
   parameter int          LENGTH   = OAM_LEN,
   parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
   input  logic        clockgb,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  indata,
   output logic [7:0]  outdata,
   input  logic        load,
   input  logic        store,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_indata,
   input  logic [7:0]  bus_outdata,
   output logic        bus_load,
   output logic        bus_store,
   output logic [7:0]  oam_address,
   output logic [7:0]  oam_indata,
   output logic        oam_store,
   output logic        busy
);

   localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

   dma_state_t state, state_nxt;
   rd_sel_t    rd_sel;
   logic [7:0] src;
   logic [7:0] idx;
   logic       wr_pend;

   logic       trig;
   logic       cpu_reg;
   logic       cpu_hram;
   logic [7:0] page;

   assign cpu_reg  = (address == REG_ADDR);
   assign cpu_hram = (address >= HRAM_LO) && (address <= HRAM_HI);
   assign trig     = store && cpu_reg;
   assign busy     = (state != ST_IDLE) || wr_pend;
   // Pages E0-FF alias the C0-DF work RAM, as on the real echo region.
   assign page     = (src < ECHO_BASE) ? src : (src - 8'h20);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_IDLE;
         ST_START: state_nxt = ST_RUN;
         ST_RUN:   if (idx == LAST_IDX) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (trig) state_nxt = ST_START;
   end

   always_ff @(posedge clockgb or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         src     <= 8'h00;
         idx     <= 8'h00;
         wr_pend <= 1'b0;
      end else begin
         state <= state_nxt;
         if (trig) begin
            src     <= indata;
            idx     <= 8'h00;
            wr_pend <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  idx     <= idx + 8'd1;
                  wr_pend <= 1'b1;
               end
               ST_IDLE: wr_pend <= 1'b0;
               default: wr_pend <= wr_pend;
            endcase
         end
      end
   end

   always_ff @(posedge clockgb or posedge reset) begin
      if (reset) begin
         rd_sel <= SEL_BUS;
      end else if (load) begin
         if (cpu_reg)
            rd_sel <= SEL_SRC;
         else if (busy && !cpu_hram)
            rd_sel <= SEL_FF;
         else
            rd_sel <= SEL_BUS;
      end
   end

   always_comb begin
      bus_address = address;
      bus_indata  = indata;
      bus_load    = load  && !cpu_reg;
      bus_store   = store && !cpu_reg;
      if (state == ST_RUN) begin
         bus_address = {page, idx};
         bus_load    = 1'b1;
         bus_store   = 1'b0;
      end else if (busy) begin
         bus_load    = load  && cpu_hram;
         bus_store   = store && cpu_hram;
      end
   end

   // A trigger landing on a pending write drops that byte.
   assign oam_store   = wr_pend && !trig;
   assign oam_address = wr_pend ? (idx - 8'd1) : 8'h00;
   assign oam_indata  = wr_pend ? bus_outdata : 8'h00;

   always_comb begin
      outdata = bus_outdata;
      case (rd_sel)
         SEL_SRC: outdata = src;
         SEL_FF:  outdata = 8'hff;
         default: outdata = bus_outdata;
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a 64 KiB bus memory model (1-cycle read
// latency) and an OAM capture array.
module tb_oam_dma;

   logic        clockgb;
   logic        reset;
   logic [15:0] address;
   logic [7:0]  indata;
   logic [7:0]  outdata;
   logic        load;
   logic        store;
   logic [15:0] bus_address;
   logic [7:0]  bus_indata;
   logic [7:0]  bus_outdata;
   logic        bus_load;
   logic        bus_store;
   logic [7:0]  oam_address;
   logic [7:0]  oam_indata;
   logic        oam_store;
   logic        busy;

   logic [7:0] mem [0:65535];
   logic [7:0] oam_mem [0:255];

   int tests = 0;
   int fails = 0;
   int busy_cnt = 0;
   int oam_cnt = 0;
   int seq_err = 0;
   logic [7:0] exp_oam = 8'h00;

   oam_dma dut (
      .clockgb     (clockgb),
      .reset       (reset),
      .address     (address),
      .indata      (indata),
      .outdata     (outdata),
      .load        (load),
      .store       (store),
      .bus_address (bus_address),
      .bus_indata  (bus_indata),
      .bus_outdata (bus_outdata),
      .bus_load    (bus_load),
      .bus_store   (bus_store),
      .oam_address (oam_address),
      .oam_indata  (oam_indata),
      .oam_store   (oam_store),
      .busy        (busy)
   );

   initial clockgb = 1'b0;
   always #5 clockgb = ~clockgb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs mid-cycle, service the bus model, advance.
   task automatic step();
      logic [7:0] rd;
      logic       rd_v;
      #1;
      rd   = 8'h00;
      rd_v = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (oam_store === 1'b1) begin
         if (oam_address !== exp_oam) seq_err++;
         exp_oam = oam_address + 8'd1;
         oam_mem[oam_address] = oam_indata;
         oam_cnt++;
      end
      if (bus_store === 1'b1) mem[bus_address] = bus_indata;
      if (bus_load === 1'b1) begin
         rd   = mem[bus_address];
         rd_v = 1'b1;
      end
      @(posedge clockgb);
      if (rd_v) bus_outdata = rd;
      @(negedge clockgb);
   endtask

   task automatic run_idle(input int bound);
      int n;
      n = 0;
      while (busy === 1'b1 && n < bound) begin
         step();
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic trigger(input logic [7:0] pg);
      address = 16'hff46;
      indata  = pg;
      store   = 1'b1;
      step();
      store   = 1'b0;
      address = 16'h0000;
      indata  = 8'h00;
   endtask

   initial begin
      int errs;
      reset       = 1'b1;
      address     = 16'h0000;
      indata      = 8'h00;
      load        = 1'b0;
      store       = 1'b0;
      bus_outdata = 8'h00;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
      for (int i = 0; i < 160; i++) begin
         mem[16'hc100 + i] = 8'(i) ^ 8'h5a;
         mem[16'hc200 + i] = 8'(i) ^ 8'ha5;
         mem[16'hd100 + i] = 8'(i * 3 + 1);
      end
      mem[16'hff44] = 8'h3c;

      // Reset values and pass-through while in reset
      @(negedge clockgb);
      step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_oam_store", {31'd0, oam_store}, 32'd0);
      chk("rst_oam_address", {24'd0, oam_address}, 32'd0);
      chk("rst_oam_indata", {24'd0, oam_indata}, 32'd0);
      address = 16'h1234;
      load    = 1'b1;
      #1;
      chk("rst_bus_load", {31'd0, bus_load}, 32'd1);
      chk("rst_bus_address", {16'd0, bus_address}, 32'h1234);
      @(negedge clockgb);
      load    = 1'b0;
      address = 16'h0000;
      reset   = 1'b0;
      step();

      // Full copy from page C1 with CPU accesses during RUN
      busy_cnt = 0; oam_cnt = 0; seq_err = 0; exp_oam = 8'h00;
      trigger(8'hc1);
      chk("c1_busy_rise", {31'd0, busy}, 32'd1);
      step();
      address = 16'hc000; load = 1'b1;
      step();
      load = 1'b0;
      chk("run_load_c000", {24'd0, outdata}, 32'hff);
      address = 16'h8000; indata = 8'h77; store = 1'b1;
      #1;
      chk("run_store_8000", {31'd0, bus_store}, 32'd0);
      step();
      store = 1'b0;
      address = 16'hff46; load = 1'b1;
      step();
      load = 1'b0; address = 16'h0000;
      chk("run_load_ff46", {24'd0, outdata}, 32'hc1);
      run_idle(300);
      chk("c1_busy_span", busy_cnt, 162);
      chk("c1_oam_count", oam_cnt, 160);
      chk("c1_oam_seq", seq_err, 0);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (oam_mem[i] !== (8'(i) ^ 8'h5a)) errs++;
      chk("c1_oam_data", errs, 0);
      chk("mem_8000_untouched", {24'd0, mem[16'h8000]}, 32'd0);

      // Echo page F1 reads D100..D19F
      busy_cnt = 0; oam_cnt = 0; seq_err = 0; exp_oam = 8'h00;
      trigger(8'hf1);
      step();
      errs = 0;
      for (int k = 0; k < 160; k++) begin
         if (bus_address !== 16'(16'hd100 + k) || bus_load !== 1'b1) errs++;
         step();
      end
      chk("f1_bus_addresses", errs, 0);
      run_idle(10);
      chk("f1_busy_span", busy_cnt, 162);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (oam_mem[i] !== 8'(i * 3 + 1)) errs++;
      chk("f1_oam_data", errs, 0);

      // Retrigger with C2 at read index 50
      trigger(8'hc1);
      for (int k = 0; k < 51; k++) step();
      chk("retrig_at_idx50", {16'd0, bus_address}, 32'hc132);
      address = 16'hff46; indata = 8'hc2; store = 1'b1;
      #1;
      chk("retrig_drop_write", {31'd0, oam_store}, 32'd0);
      step();
      store = 1'b0; address = 16'h0000; indata = 8'h00;
      busy_cnt = 0; oam_cnt = 0; seq_err = 0; exp_oam = 8'h00;
      run_idle(300);
      chk("retrig_busy_span", busy_cnt, 162);
      chk("retrig_oam_count", oam_cnt, 160);
      chk("retrig_oam_seq", seq_err, 0);
      chk("retrig_oam0", {24'd0, oam_mem[0]}, 32'ha5);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (oam_mem[i] !== (8'(i) ^ 8'ha5)) errs++;
      chk("retrig_oam_data", errs, 0);

      // Reset asserted at read index 80
      oam_cnt = 0; seq_err = 0; exp_oam = 8'h00;
      trigger(8'hc1);
      for (int k = 0; k < 81; k++) step();
      chk("pre_rst_addr", {16'd0, bus_address}, 32'hc150);
      reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_oam_store", {31'd0, oam_store}, 32'd0);
      for (int k = 0; k < 3; k++) step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("midrst_oam_count", oam_cnt, 79);
      chk("midrst_oam78", {24'd0, oam_mem[78]}, {24'd0, 8'd78 ^ 8'h5a});
      chk("midrst_oam79_kept", {24'd0, oam_mem[79]}, {24'd0, 8'd79 ^ 8'ha5});
      chk("midrst_idle", {31'd0, busy}, 32'd0);

      // IDLE pass-through read of FF44
      address = 16'hff44; load = 1'b1;
      #1;
      chk("idle_bus_address", {16'd0, bus_address}, 32'hff44);
      chk("idle_bus_load", {31'd0, bus_load}, 32'd1);
      step();
      load = 1'b0; address = 16'h0000;
      chk("idle_outdata", {24'd0, outdata}, 32'h3c);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
